// File: rtl/fsm_interval_timer.sv
// Interval timer for the comparison/Gray FSM: prescales the clock into count units and
// flags when the requested number of units has elapsed. Optional pause input under FSM_TIMER_PAUSE_EN.
module fsm_interval_timer #(
  parameter int TICK_CYCLES = 50000000,
  parameter int CNT_W       = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             initCount,
  input  logic [CNT_W-1:0] countVal,
`ifdef FSM_TIMER_PAUSE_EN
  input  logic             pause,
`endif
  output logic             contBETval,
  output logic [CNT_W-1:0] count,
  output logic             tick
);

  localparam int PRE_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_CYCLES - 1);

  // State is implied by armed and the count/target relation; decoded here for visibility.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [PRE_W-1:0] pre_cnt, pre_cnt_d;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] val_q, val_d;
  logic             armed, armed_d;
  logic             same_val;
  logic             restart;
  logic             advance;
  logic             hold;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pre_cnt <= '0;
      count   <= '0;
      val_q   <= '0;
      armed   <= 1'b0;
    end else begin
      pre_cnt <= pre_cnt_d;
      count   <= count_d;
      val_q   <= val_d;
      armed   <= armed_d;
    end
  end

`ifdef FSM_TIMER_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  always_comb begin
    state      = IDLE;
    pre_cnt_d  = pre_cnt;
    count_d    = count;
    val_d      = val_q;
    armed_d    = armed;
    same_val   = (countVal == val_q);
    restart    = initCount & (~armed | ~same_val);
    advance    = 1'b0;
    contBETval = 1'b0;
    tick       = 1'b0;

    if (armed) begin
      state = (count < val_q) ? RUN : DONE;
    end

    // Gated by the live inputs so a stale "done" drops in the same cycle the request changes.
    contBETval = initCount & same_val & (state == DONE);
    advance    = initCount & same_val & (state == RUN) & ~hold;
    tick       = advance & (pre_cnt == PRE_LAST);

    if (!initCount) begin
      pre_cnt_d = '0;
      count_d   = '0;
      val_d     = '0;
      armed_d   = 1'b0;
    end else if (restart) begin
      pre_cnt_d = '0;
      count_d   = '0;
      val_d     = countVal;
      armed_d   = 1'b1;
    end else if (advance) begin
      if (pre_cnt == PRE_LAST) begin
        pre_cnt_d = '0;
        count_d   = count + CNT_W'(1);
      end else begin
        pre_cnt_d = pre_cnt + PRE_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fsm_interval_timer.sv
// Directed bench for fsm_interval_timer with TICK_CYCLES=4; expected values come from
// closed-form latency formulas (count = (c-1)/T capped at N, done from cycle N*T+1).
module tb_fsm_interval_timer;

  localparam int T     = 4;
  localparam int CNT_W = 3;

  logic             clock;
  logic             reset;
  logic             initCount;
  logic [CNT_W-1:0] countVal;
  logic             pause;
  logic             contBETval;
  logic [CNT_W-1:0] count;
  logic             tick;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  fsm_interval_timer #(
    .TICK_CYCLES(T),
    .CNT_W      (CNT_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .initCount (initCount),
    .countVal  (countVal),
`ifdef FSM_TIMER_PAUSE_EN
    .pause     (pause),
`endif
    .contBETval(contBETval),
    .count     (count),
    .tick      (tick)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Lands 1 time unit after the rising edge; inputs are driven here.
  task automatic next_cyc();
    @(posedge clock);
    #1;
  endtask

  // Checks cycle c (c=0 is the cycle the request is presented) of an N-unit request.
  task automatic check_cyc(input string tag, input int c, input int n);
    int exp_count;
    logic exp_tick, exp_done;
    #1;
    exp_count = (c >= 1) ? (c - 1) / T : 0;
    if (exp_count > n) exp_count = n;
    exp_tick = (c >= 1) && (c % T == 0) && (c <= n * T);
    exp_done = (c >= n * T + 1);
    chk({tag, "_count"}, 8'(count), 8'(exp_count));
    chk({tag, "_tick"},  8'(tick), 8'(exp_tick));
    chk({tag, "_done"},  8'(contBETval), 8'(exp_done));
  endtask

  initial begin
    reset     = 1'b1;
    initCount = 1'b1;
    countVal  = 3'd6;
    pause     = 1'b0;

    // Reset held with a request pending: everything stays quiet.
    repeat (3) begin
      next_cyc();
      #1;
      chk("rst_done",  8'(contBETval), 8'd0);
      chk("rst_count", 8'(count),      8'd0);
      chk("rst_tick",  8'(tick),       8'd0);
    end
    reset = 1'b0;
    #1;
    chk("post_rst_done", 8'(contBETval), 8'd0);
    chk("post_rst_tick", 8'(tick),       8'd0);

    // First edge after release restarts; 6 units of 4 cycles.
    for (int c = 1; c <= 30; c++) begin
      next_cyc();
      check_cyc("run6", c, 6);
    end

    // Target change from DONE: done drops combinationally, then a 3-unit interval.
    next_cyc();
    countVal = 3'd3;
    #1;
    chk("chg_done_drop", 8'(contBETval), 8'd0);
    chk("chg_tick",      8'(tick),       8'd0);
    chk("chg_count_old", 8'(count),      8'd6);
    for (int c = 1; c <= 15; c++) begin
      next_cyc();
      check_cyc("run3", c, 3);
    end

    // Clear, restart, then drop initCount mid-count at count=2.
    next_cyc();
    initCount = 1'b0;
    #1;
    chk("clr_done", 8'(contBETval), 8'd0);
    next_cyc();
    initCount = 1'b1;
    #1;
    chk("clr_count",  8'(count),      8'd0);
    chk("rst3_done0", 8'(contBETval), 8'd0);
    for (int c = 1; c <= 9; c++) begin
      next_cyc();
      check_cyc("pre_drop", c, 3);
    end
    next_cyc();
    initCount = 1'b0;
    #1;
    chk("drop_count_hold", 8'(count),      8'd2);
    chk("drop_done",       8'(contBETval), 8'd0);
    chk("drop_tick",       8'(tick),       8'd0);
    next_cyc();
    #1;
    chk("drop_cleared", 8'(count), 8'd0);
    initCount = 1'b1;
    #1;
    chk("rerise_done0", 8'(contBETval), 8'd0);
    for (int c = 1; c <= 14; c++) begin
      next_cyc();
      check_cyc("rerun3", c, 3);
    end

    // Zero-length interval: done from cycle 1, no ticks.
    next_cyc();
    initCount = 1'b0;
    #1;
    chk("z_clr_done", 8'(contBETval), 8'd0);
    next_cyc();
    initCount = 1'b1;
    countVal  = 3'd0;
    #1;
    chk("z_done0", 8'(contBETval), 8'd0);
    chk("z_tick0", 8'(tick),       8'd0);
    for (int c = 1; c <= 6; c++) begin
      next_cyc();
      check_cyc("zero", c, 0);
    end

    // Asynchronous reset mid-count clears state immediately.
    next_cyc();
    countVal = 3'd5;
    #1;
    chk("r5_done0", 8'(contBETval), 8'd0);
    for (int c = 1; c <= 10; c++) begin
      next_cyc();
      check_cyc("run5", c, 5);
    end
    reset = 1'b1;
    #1;
    chk("async_rst_count", 8'(count),      8'd0);
    chk("async_rst_done",  8'(contBETval), 8'd0);
    next_cyc();
    reset = 1'b0;
    #1;
    chk("rel_count", 8'(count),      8'd0);
    chk("rel_done",  8'(contBETval), 8'd0);
    chk("rel_tick",  8'(tick),       8'd0);
    for (int c = 1; c <= 6; c++) begin
      next_cyc();
      check_cyc("rerun5", c, 5);
    end

`ifdef FSM_TIMER_PAUSE_EN
    // Pause for 10 cycles at count=1 shifts completion from cycle 13 to 23.
    next_cyc();
    countVal = 3'd3;
    #1;
    chk("p_done0", 8'(contBETval), 8'd0);
    for (int c = 1; c <= 25; c++) begin
      next_cyc();
      pause = (c >= 6 && c <= 15);
      if (pause) begin
        #1;
        chk("pause_count", 8'(count),      8'd1);
        chk("pause_tick",  8'(tick),       8'd0);
        chk("pause_done",  8'(contBETval), 8'd0);
      end else begin
        check_cyc("pause_run", (c > 15) ? c - 10 : c, 3);
      end
    end
    pause = 1'b0;
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
